// File: rtl/div_pkg.sv
// Shared definitions for the signed restoring divider: FSM state encoding
// and the default operand width.
package div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One stateless restoring-division iteration: trial-subtract the divisor from
// the shifted partial remainder and keep the difference only if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   shifted_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   divisor_ext;
  logic [WIDTH-1:0] trial;

  assign divisor_ext = {1'b0, divisor_i};

  // The compare is WIDTH+1 bits wide; when it succeeds the true difference is
  // below the divisor, so a WIDTH-bit modular subtraction yields it exactly.
  assign q_o   = (shifted_i >= divisor_ext);
  assign trial = shifted_i[WIDTH-1:0] - divisor_i;
  assign rem_o = q_o ? trial : shifted_i[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Signed iterative divider: magnitudes are divided MSB-first over WIDTH
// cycles, then quotient/remainder signs are fixed up (truncating division).
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;

  logic [WIDTH:0]   shifted_d;
  logic [WIDTH-1:0] rem_d;
  logic             qbit_d;

  // quo_q starts as |a| and is shifted out MSB-first while quotient bits enter.
  assign shifted_d = {rem_q, quo_q[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .shifted_i (shifted_d),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .q_o       (qbit_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_q <= a[WIDTH-1];
            quo_q     <= a[WIDTH-1] ? (~a + 1'b1) : a;
            dvs_q     <= b[WIDTH-1] ? (~b + 1'b1) : b;
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            dz_q      <= 1'b0;
            if (b == '0) begin
              lo_q    <= '1;
              hi_q    <= a;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[WIDTH-2:0], qbit_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          lo_q    <= neg_quo_q ? (~quo_q + 1'b1) : quo_q;
          hi_q    <= neg_rem_q ? (~rem_q + 1'b1) : rem_q;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign lo        = lo_q;
  assign hi        = hi_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus random operands, checked
// against a signed-arithmetic reference model with timing checks.
module tb_div_unit;
  import div_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  state_t       dbg_state;

  int cmp_cnt = 0;
  int err_cnt = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .lo        (lo),
    .hi        (hi),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: signed truncating division in wider arithmetic
  task automatic model(input logic [W-1:0] ea, input logic [W-1:0] eb,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz);
    longint la;
    longint lb;
    if (eb == '0) begin
      q  = '1;
      r  = ea;
      dz = 1'b1;
    end else begin
      la = longint'($signed(ea));
      lb = longint'($signed(eb));
      q  = W'(la / lb);
      r  = W'(la % lb);
      dz = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic accept(input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    bit seen;
    bit busy_ok;
    n       = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " busy_high"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    model(ea, eb, eq, er, edz);
    chk({tag, " lo"}, lo, eq);
    chk({tag, " hi"}, hi, er);
    chk({tag, " div_zero"}, 32'(div_zero), 32'(edz));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb);
    logic [W-1:0] lo_s;
    accept(va, vb);
    wait_done(tag, (vb == '0) ? 1 : LAT);
    check_result(tag, va, vb);
    lo_s = lo;
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " lo_held"}, lo, lo_s);
  endtask

  // Stimulus
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           no_done;

    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst div_zero", 32'(div_zero), 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;

    run_op("d100_7", 32'd100, 32'd7);
    run_op("dm7_2", 32'hFFFF_FFF9, 32'd2);
    run_op("d7_m2", 32'd7, 32'hFFFF_FFFE);
    run_op("dzero", 32'h1234_5678, 32'd0);
    run_op("dz_clear", 32'd9, 32'd3);
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("min_by_1", 32'h8000_0000, 32'd1);
    run_op("min_by_min", 32'h8000_0000, 32'h8000_0000);
    run_op("small_by_min", 32'd5, 32'h8000_0000);
    run_op("neg_by_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9);

    // Start and operand changes mid-CALC must be ignored
    accept(32'd1000, 32'd33);
    repeat (10) @(negedge clk);
    start = 1'b1;
    a     = 32'd55;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start", LAT - 11);
    check_result("ignore_start", 32'd1000, 32'd33);

    // Start held high across done: second op accepted in the following IDLE cycle
    @(negedge clk);
    start = 1'b1;
    a     = 32'hFFFF_FC18;
    b     = 32'd7;
    @(posedge clk);
    #1;
    a = 32'd77;
    b = 32'd10;
    wait_done("hold1", LAT);
    check_result("hold1", 32'hFFFF_FC18, 32'd7);
    @(negedge clk);
    chk("hold idle done", 32'(done), 32'd0);
    chk("hold idle busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("hold2", LAT);
    check_result("hold2", 32'd77, 32'd10);

    // Reset mid-CALC aborts without a done pulse
    accept(32'd12345, 32'd11);
    repeat (15) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort lo", lo, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort div_zero", 32'(div_zero), 32'd0);
    chk("abort state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    no_done = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    chk("abort no_done", 32'(no_done), 32'd1);
    run_op("after_abort", 32'hFFFF_FF00, 32'd3);

    // Random operands
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = W'($urandom_range(1, 15));
        2: rb = -W'($urandom_range(1, 15));
        default: rb = ($urandom_range(0, 5) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(8, 31);
      run_op($sformatf("rand%0d", i), ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
